uart_tx: RTL
============

# uart_tx

- Serialises bytes onto the UART line: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- It is the transmit end of the same link that `uart_rx` receives, and its default frame (even parity, 9600 baud, 100 MHz) matches that receiver.
- A one-entry holding register lets the upstream logic queue the next byte while the current frame is shifting, so consecutive frames go out with no idle gap.

## Interface

- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate in bits per second.
- `CLKS_PER_BIT`, `CLK_FREQ/BAUD_RATE` (10416), clock cycles per bit, integer-truncated; must be ≥ 2.
- `PARITY_EN`, 1, 1 = parity bit present (11-bit frame); 0 = no parity bit (10-bit frame).
- `PARITY_ODD`, 0, 0 = even parity (parity bit = ^data); 1 = odd parity (parity bit = ~^data).
- `clk`  in  1  system clock; one clock domain only; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tx_data`  in  8  byte to send; sampled only on an accepting edge.
- `tx_valid`  in  1  upstream has a byte on `tx_data`.
- `tx_ready`  out  1  holding register empty; equals `!hold_valid` (combinational from a flop).
- `tx`  out  1  serial line; registered output; idle level is 1.
- `tx_busy`  out  1  a frame is on the line (FSM not in IDLE); registered.
- `tx_done`  out  1  one-cycle pulse at the end of each stop bit; registered.

## Operation

- **Accept:**
  - A byte is accepted on any edge where `tx_valid && tx_ready`.
  - The byte is written to `hold_data` and `hold_valid` is set to 1.
  - Acceptance is legal in any FSM state.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** `tx` = 1. If `hold_valid` = 1, go to START on the next edge. On that edge: load the shift register from `hold_data`, clear `hold_valid`, compute and latch the parity bit, clear `bit_cnt` and `clk_cnt`.
  - **START:** `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - **DATA:** `tx` = `shift[0]`. Every `CLKS_PER_BIT` cycles, shift right and increment `bit_cnt`. After bit 7, go to PARITY if `PARITY_EN`, otherwise go to STOP.
  - **PARITY:** `tx` = latched parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
  - **STOP:** `tx` = 1 for `CLKS_PER_BIT` cycles. On the final edge, pulse `tx_done`. If `hold_valid` = 1, go straight to START, performing the same load/clear as the IDLE→START transition. Otherwise go to IDLE.
- **Counter width:**
  - `clk_cnt` is `$clog2(CLKS_PER_BIT)` bits.
  - A bit ends on the edge where `clk_cnt == CLKS_PER_BIT-1`; `clk_cnt` then wraps to 0.
  - `bit_cnt` is 3 bits and wraps from 7 to 0.
- **No simultaneous accept and consume:**
  - Consumption happens only when `hold_valid` = 1, and acceptance requires `tx_ready` = 1 (`hold_valid` = 0).
  - The two can therefore never coincide, and there is no need for a priority rule between them.
- **Mid-frame reset:**
  - `rst_n` = 0 sampled on an edge aborts any frame and drops the holding register contents.
  - `tx` returns to 1 on that same edge. A truncated frame on the line is acceptable.
- **Input stability:** `tx_data` may change freely while `tx_ready` = 0, or while `tx_valid` = 0.

## Timing

- **Reset values:**
  - `tx` = 1, `tx_busy` = 0, `tx_done` = 0, `tx_ready` = 1.
  - `hold_valid` = 0, state = IDLE, all counters 0.
- **Start latency:** if a byte is accepted on edge N while the FSM is IDLE, `tx` falls after edge N+1. `tx_busy` rises on the same edge.
- **Bit duration:** every bit, including start and stop, lasts exactly `CLKS_PER_BIT` cycles.
- **Frame length:** `(10 + PARITY_EN) * CLKS_PER_BIT` cycles.
- **`tx_done`:** high for exactly one cycle, in the cycle after the last stop-bit edge.
- **`tx_busy`:**
  - Falls on that same edge if no byte is pending.
  - Stays 1 across back-to-back frames.
- **`tx_ready`:**
  - Returns to 1 one cycle after the FSM consumes the holding register.
  - Therefore at most one byte waits while another is shifting.
- **Back-to-back frames:** the START of the next frame begins on the edge immediately after the last stop-bit cycle, with zero idle gap.

## Test plan

Bench parameters: `CLK_FREQ`=160, `BAUD_RATE`=10 (`CLKS_PER_BIT`=16).

- **Reset:** hold `rst_n`=0 for 3 cycles, then release. Require `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 throughout.
- **Single byte 0x55, even parity:**
  - Require the line sequence 0,1,0,1,0,1,0,1,0, parity 0, stop 1, each bit 16 cycles.
  - Require `tx` to fall 1 cycle after acceptance.
  - Require `tx_done` to pulse once, 176 cycles after `tx` falls.
- **Parity values:**
  - Byte 0x07 → parity bit 1.
  - With `PARITY_ODD`=1: 0x07 → parity 0.
  - With `PARITY_EN`=0: frame is 160 cycles with no parity bit.
- **Back-to-back frames:**
  - Hold `tx_valid`=1 continuously with 0xA3 then 0x3C.
  - Require the second byte to be accepted during the first frame.
  - Require the second start bit on the cycle immediately after the first stop bit.
  - Require `tx_busy` to stay 1 for 352 cycles.
  - Require two `tx_done` pulses, 176 cycles apart.
- **Backpressure:** present a third byte while `tx_ready`=0. Require it to be held off until the hold register empties, then sent intact.
- **Mid-frame reset:**
  - Assert `rst_n`=0 during data bit 3 of 0xF0.
  - Require `tx`=1 and `tx_busy`=0 on the next edge.
  - Require no `tx_done` pulse.
  - After release, a new byte 0x81 transmits correctly.
- **Loopback:** connect `tx` to a `uart_rx` instance and send 0x00, 0xFF, 0x5A. Require matching `data_out` values and `parity_error`=0.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmitter with a one-entry holding register.
//
// Frame: 1 start bit (0), 8 data bits LSB first, optional parity bit,
// 1 stop bit (1). Each bit lasts CLKS_PER_BIT clock cycles. The holding
// register lets upstream queue the next byte while the current frame is
// shifting, so back-to-back frames leave no idle gap on the line.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   tx_data   in   [7:0] byte to send, sampled when tx_valid && tx_ready
//   tx_valid  in   upstream has a byte on tx_data
//   tx_ready  out  holding register empty (direct from hold-valid flop)
//   tx        out  serial line, registered, idles high
//   tx_busy   out  a frame is on the line, registered
//   tx_done   out  one-cycle pulse after the last stop-bit edge, registered
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state;
    logic             r_hold_valid;
    logic [7:0]       r_hold_data;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;

    logic w_bit_end;
    logic w_accept;
    logic w_load;

    function automatic logic parity_of(input logic [7:0] d);
        return PARITY_ODD ? ~^d : ^d;
    endfunction

    assign w_bit_end = (r_clk_cnt == LAST_CNT);
    assign w_accept  = tx_valid && !r_hold_valid;
    // The holding register is consumed either from IDLE or on the final
    // stop-bit edge, which is what makes back-to-back frames gapless.
    assign w_load    = r_hold_valid && ((r_state == S_IDLE) ||
                                        ((r_state == S_STOP) && w_bit_end));

    assign tx_ready = !r_hold_valid;
    assign tx       = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

    // Control: state, counters, hold-valid flag and registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_hold_valid <= 1'b0;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Accept and consume are mutually exclusive: accept needs the
            // flag low, consume needs it high.
            if (w_accept) begin
                r_hold_valid <= 1'b1;
            end

            if (r_state != S_IDLE) begin
                r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_load) begin
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            if (PARITY_EN) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            // shift[1] becomes shift[0] on this same edge
                            r_tx <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_done <= 1'b1;
                        if (w_load) begin
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= 1'b1;
                end
            endcase

            if (w_load) begin
                r_hold_valid <= 1'b0;
                r_clk_cnt    <= '0;
                r_bit_cnt    <= '0;
            end
        end
    end

    // Data: holding register, shift register and latched parity bit.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold_data <= tx_data;
        end
        if (w_load) begin
            r_shift  <= r_hold_data;
            r_parity <= parity_of(r_hold_data);
        end else if ((r_state == S_DATA) && w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

endmodule
